// File: rtl/irq_ctrl148_pkg.sv
// irq_ctrl148_pkg: shared constants, state encoding and helpers for the irq_ctrl148 interrupt controller.
package irq_ctrl148_pkg;

    localparam int NUM_IRQ = 8;
    localparam int VEC_W   = 3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] SERV = 2'd2;

    // One-hot mask selecting the line numbered n.
    function automatic logic [NUM_IRQ-1:0] bit_of(input logic [VEC_W-1:0] n);
        return {{(NUM_IRQ-1){1'b0}}, 1'b1} << n;
    endfunction

endpackage

// File: rtl/irq_ctrl148_hc148.sv
// hc148: 8-to-3 priority encoder modelled on the 74HC148, all signals active-low.
//   in_N  [7:0] request inputs, bit 7 highest priority
//   ei_N        enable input, high forces out_N=111 and gs_N=1
//   out_N [2:0] inverted index of the highest active input
//   gs_N        low when enabled and at least one input is active
module hc148 (
    input  logic [7:0] in_N,
    input  logic       ei_N,
    output logic [2:0] out_N,
    output logic       gs_N
);

    logic [2:0] idx;
    logic       any;

    // Ascending scan so the highest active index is the last one written.
    always_comb begin
        idx = 3'd0;
        any = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!in_N[i]) begin
                idx = 3'(i);
                any = 1'b1;
            end
        end
    end

    assign out_N = ei_N ? 3'b111 : ~idx;
    assign gs_N  = ei_N | ~any;

endmodule

// File: rtl/irq_ctrl148.sv
// irq_ctrl148: 8-line prioritised interrupt controller with acknowledge / end-of-interrupt handshake.
//   TRIG_EDGE   1 = falling-edge requests latched in pend, 0 = level requests
//   clk         clock, rising edge
//   rst_N       synchronous active-low reset
//   EI_N        global enable, active-low; high blocks new requests to the CPU
//   irq_N [7:0] request lines, active-low, bit 7 highest priority
//   mask  [7:0] 1 = line excluded from arbitration (pending still latches)
//   inta        CPU acknowledge pulse
//   eoi         CPU end-of-interrupt pulse
//   int_N       registered interrupt request to CPU, active-low
//   vec   [2:0] registered number of the selected line
//   pend  [7:0] pending register
//   isr   [7:0] in-service register, one-hot or zero
module irq_ctrl148
    import irq_ctrl148_pkg::*;
#(
    parameter bit TRIG_EDGE = 1'b1
) (
    input  logic               clk,
    input  logic               rst_N,
    input  logic               EI_N,
    input  logic [NUM_IRQ-1:0] irq_N,
    input  logic [NUM_IRQ-1:0] mask,
    input  logic               inta,
    input  logic               eoi,
    output logic               int_N,
    output logic [VEC_W-1:0]   vec,
    output logic [NUM_IRQ-1:0] pend,
    output logic [NUM_IRQ-1:0] isr
);

    logic [1:0]         state;
    logic [NUM_IRQ-1:0] prev;
    logic [NUM_IRQ-1:0] cand;
    logic [NUM_IRQ-1:0] pend_nxt;
    logic [NUM_IRQ-1:0] ack_bits;
    logic [VEC_W-1:0]   out_N;
    logic [VEC_W-1:0]   win;
    logic               gs_N;
    logic               ack;

    assign cand = pend & ~mask;

    // EI_N gates the encoder, so gs_N low means "a request may be presented".
    hc148 u_enc (
        .in_N  (~cand),
        .ei_N  (EI_N),
        .out_N (out_N),
        .gs_N  (gs_N)
    );

    // Acknowledge clears the line already presented on vec; a new edge on the
    // same line in the same cycle re-sets it because set is OR-ed in last.
    always_comb begin
        win      = ~out_N;
        ack      = (state == REQ) && inta && (cand != '0);
        ack_bits = ack ? bit_of(vec) : '0;
        pend_nxt = TRIG_EDGE ? ((pend & ~ack_bits) | (prev & ~irq_N)) : ~irq_N;
    end

    always_ff @(posedge clk) begin
        if (!rst_N) begin
            state <= IDLE;
            pend  <= '0;
            prev  <= '1;
            isr   <= '0;
            int_N <= 1'b1;
            vec   <= '0;
        end else begin
            prev <= irq_N;
            pend <= pend_nxt;
            case (state)
                IDLE: begin
                    if (!gs_N) begin
                        state <= REQ;
                        int_N <= 1'b0;
                        vec   <= win;
                    end
                end
                REQ: begin
                    if (ack) begin
                        state <= SERV;
                        isr   <= bit_of(vec);
                        int_N <= 1'b1;
                    end else if (gs_N) begin
                        state <= IDLE;
                        int_N <= 1'b1;
                    end else begin
                        vec <= win;
                    end
                end
                SERV: begin
                    if (eoi) begin
                        state <= IDLE;
                        isr   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl148.sv
// tb_irq_ctrl148: self-checking bench for irq_ctrl148 in edge and level modes against a behavioural model.
module tb_irq_ctrl148;

    logic       clk = 1'b0;
    logic       rst_N = 1'b0;
    logic       EI_N = 1'b0;
    logic [7:0] irq_N = 8'hFF;
    logic [7:0] mask = 8'h00;
    logic       inta = 1'b0;
    logic       eoi = 1'b0;

    logic       int_e, int_l;
    logic [2:0] vec_e, vec_l;
    logic [7:0] pend_e, pend_l, isr_e, isr_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irq_ctrl148 dut_e (
        .clk(clk), .rst_N(rst_N), .EI_N(EI_N), .irq_N(irq_N), .mask(mask),
        .inta(inta), .eoi(eoi), .int_N(int_e), .vec(vec_e), .pend(pend_e), .isr(isr_e)
    );

    irq_ctrl148 #(.TRIG_EDGE(1'b0)) dut_l (
        .clk(clk), .rst_N(rst_N), .EI_N(EI_N), .irq_N(irq_N), .mask(mask),
        .inta(inta), .eoi(eoi), .int_N(int_l), .vec(vec_l), .pend(pend_l), .isr(isr_l)
    );

    // Behavioural model, index 0 = level mode, 1 = edge mode.
    logic [7:0] m_pend[2], m_prev[2], m_isr[2];
    logic       m_int[2];
    logic [2:0] m_vec[2];
    bit         m_presenting[2], m_serving[2];

    function automatic int top_bit(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    function automatic void step(input int m);
        logic [7:0] cand, np;
        int w;
        bit acked;
        if (!rst_N) begin
            m_pend[m] = 8'h00; m_prev[m] = 8'hFF; m_isr[m] = 8'h00;
            m_int[m] = 1'b1; m_vec[m] = 3'd0; m_presenting[m] = 0; m_serving[m] = 0;
            return;
        end
        cand  = m_pend[m] & ~mask;
        w     = top_bit(cand);
        acked = m_presenting[m] && inta && (w >= 0);
        for (int i = 0; i < 8; i++) begin
            if (m == 0) np[i] = !irq_N[i];
            else np[i] = (m_prev[m][i] && !irq_N[i]) || (m_pend[m][i] && !(acked && i == int'(m_vec[m])));
        end
        if (m_serving[m]) begin
            if (eoi) begin m_serving[m] = 0; m_isr[m] = 8'h00; end
        end else if (m_presenting[m]) begin
            if (acked) begin
                m_presenting[m] = 0; m_serving[m] = 1; m_int[m] = 1'b1;
                m_isr[m] = 8'h00;
                m_isr[m][m_vec[m]] = 1'b1;
            end else if (EI_N || w < 0) begin
                m_presenting[m] = 0; m_int[m] = 1'b1;
            end else begin
                m_vec[m] = 3'(w);
            end
        end else if (!EI_N && w >= 0) begin
            m_presenting[m] = 1; m_int[m] = 1'b0; m_vec[m] = 3'(w);
        end
        m_pend[m] = np;
        m_prev[m] = irq_N;
    endfunction

    task automatic tick();
        @(posedge clk);
        step(0);
        step(1);
        #1;
    endtask

    task automatic do_reset();
        rst_N = 1'b0; inta = 1'b0; eoi = 1'b0;
        tick();
        tick();
        rst_N = 1'b1;
    endtask

    task automatic test_reset();
        irq_N = 8'hFF; EI_N = 1'b0; mask = 8'h00;
        do_reset();
        checks++; if ({int_e, vec_e, pend_e, isr_e} !== {1'b1, 3'd0, 8'h00, 8'h00}) begin errors++;
            $display("FAIL reset_edge: got int=%b vec=%0d pend=%h isr=%h want 1 0 00 00", int_e, vec_e, pend_e, isr_e); end
        checks++; if ({int_l, vec_l, pend_l, isr_l} !== {1'b1, 3'd0, 8'h00, 8'h00}) begin errors++;
            $display("FAIL reset_level: got int=%b vec=%0d pend=%h isr=%h want 1 0 00 00", int_l, vec_l, pend_l, isr_l); end
        for (int n = 0; n < 10; n++) tick();
        checks++; if ({int_e, pend_e, isr_e} !== {1'b1, 8'h00, 8'h00}) begin errors++;
            $display("FAIL quiet_idle: got int=%b pend=%h isr=%h want 1 00 00", int_e, pend_e, isr_e); end
    endtask

    task automatic test_single();
        do_reset();
        irq_N = 8'hDF;
        tick();
        checks++; if ({int_e, pend_e} !== {1'b1, 8'h20}) begin errors++;
            $display("FAIL single_latch: got int=%b pend=%h want 1 20", int_e, pend_e); end
        tick();
        checks++; if ({int_e, vec_e} !== {1'b0, 3'd5}) begin errors++;
            $display("FAIL single_req: got int=%b vec=%0d want 0 5", int_e, vec_e); end
        inta = 1'b1; tick(); inta = 1'b0;
        checks++; if ({int_e, vec_e, pend_e, isr_e} !== {1'b1, 3'd5, 8'h00, 8'h20}) begin errors++;
            $display("FAIL single_ack: got int=%b vec=%0d pend=%h isr=%h want 1 5 00 20", int_e, vec_e, pend_e, isr_e); end
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        checks++; if ({int_e, vec_e, isr_e} !== {1'b1, 3'd5, 8'h00}) begin errors++;
            $display("FAIL single_eoi: got int=%b vec=%0d isr=%h want 1 5 00", int_e, vec_e, isr_e); end
        irq_N = 8'hFF; tick();
    endtask

    task automatic test_priority();
        do_reset();
        irq_N = 8'hBB;
        tick();
        tick();
        checks++; if ({int_e, vec_e, pend_e} !== {1'b0, 3'd6, 8'h44}) begin errors++;
            $display("FAIL prio_first: got int=%b vec=%0d pend=%h want 0 6 44", int_e, vec_e, pend_e); end
        inta = 1'b1; tick(); inta = 1'b0;
        checks++; if ({isr_e, pend_e} !== {8'h40, 8'h04}) begin errors++;
            $display("FAIL prio_ack: got isr=%h pend=%h want 40 04", isr_e, pend_e); end
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        checks++; if ({int_e, vec_e} !== {1'b0, 3'd2}) begin errors++;
            $display("FAIL prio_second: got int=%b vec=%0d want 0 2", int_e, vec_e); end
        inta = 1'b1; tick(); inta = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
        irq_N = 8'hFF;
        do_reset();
        mask = 8'h04; irq_N = 8'hFB;
        tick(); tick(); tick();
        checks++; if ({int_e, pend_e} !== {1'b1, 8'h04}) begin errors++;
            $display("FAIL masked: got int=%b pend=%h want 1 04", int_e, pend_e); end
        mask = 8'h00; irq_N = 8'hFF;
    endtask

    task automatic test_preempt();
        do_reset();
        irq_N = 8'hFD;
        tick(); tick();
        checks++; if ({int_e, vec_e} !== {1'b0, 3'd1}) begin errors++;
            $display("FAIL preempt_low: got int=%b vec=%0d want 0 1", int_e, vec_e); end
        irq_N = 8'h7D;
        tick();
        checks++; if ({vec_e, pend_e} !== {3'd1, 8'h82}) begin errors++;
            $display("FAIL preempt_latch: got vec=%0d pend=%h want 1 82", vec_e, pend_e); end
        tick();
        checks++; if ({int_e, vec_e} !== {1'b0, 3'd7}) begin errors++;
            $display("FAIL preempt_vec: got int=%b vec=%0d want 0 7", int_e, vec_e); end
        inta = 1'b1; tick(); inta = 1'b0;
        checks++; if ({isr_e, pend_e} !== {8'h80, 8'h02}) begin errors++;
            $display("FAIL preempt_ack: got isr=%h pend=%h want 80 02", isr_e, pend_e); end
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        checks++; if ({int_e, vec_e} !== {1'b0, 3'd1}) begin errors++;
            $display("FAIL preempt_resume: got int=%b vec=%0d want 0 1", int_e, vec_e); end
        irq_N = 8'hFF;
    endtask

    task automatic test_cancel();
        do_reset();
        irq_N = 8'hF7;
        tick(); tick();
        EI_N = 1'b1;
        tick();
        checks++; if ({int_e, pend_e} !== {1'b1, 8'h08}) begin errors++;
            $display("FAIL cancel: got int=%b pend=%h want 1 08", int_e, pend_e); end
        tick();
        EI_N = 1'b0;
        tick();
        checks++; if ({int_e, vec_e} !== {1'b0, 3'd3}) begin errors++;
            $display("FAIL cancel_rearm: got int=%b vec=%0d want 0 3", int_e, vec_e); end
        inta = 1'b1; tick(); inta = 1'b0;
        EI_N = 1'b1;
        tick();
        checks++; if ({int_e, isr_e} !== {1'b1, 8'h08}) begin errors++;
            $display("FAIL serv_ei: got int=%b isr=%h want 1 08", int_e, isr_e); end
        rst_N = 1'b0;
        tick();
        checks++; if ({int_e, vec_e, pend_e, isr_e} !== {1'b1, 3'd0, 8'h00, 8'h00}) begin errors++;
            $display("FAIL serv_reset: got int=%b vec=%0d pend=%h isr=%h want 1 0 00 00", int_e, vec_e, pend_e, isr_e); end
        rst_N = 1'b1;
        tick();
        checks++; if (pend_e !== 8'h08) begin errors++;
            $display("FAIL post_reset_edge: got pend=%h want 08", pend_e); end
        EI_N = 1'b0; irq_N = 8'hFF;
    endtask

    task automatic test_level();
        do_reset();
        irq_N = 8'hF7;
        tick();
        checks++; if (pend_l !== 8'h08) begin errors++;
            $display("FAIL level_pend: got pend=%h want 08", pend_l); end
        tick();
        checks++; if ({int_l, vec_l} !== {1'b0, 3'd3}) begin errors++;
            $display("FAIL level_req: got int=%b vec=%0d want 0 3", int_l, vec_l); end
        inta = 1'b1; tick(); inta = 1'b0;
        checks++; if ({int_l, isr_l, pend_l} !== {1'b1, 8'h08, 8'h08}) begin errors++;
            $display("FAIL level_ack: got int=%b isr=%h pend=%h want 1 08 08", int_l, isr_l, pend_l); end
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        checks++; if ({int_l, vec_l, isr_l} !== {1'b0, 3'd3, 8'h00}) begin errors++;
            $display("FAIL level_reassert: got int=%b vec=%0d isr=%h want 0 3 00", int_l, vec_l, isr_l); end
        irq_N = 8'hFF;
    endtask

    task automatic test_random();
        logic [19:0] got, want;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            irq_N = irq_N ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 15) == 0) mask = 8'($urandom) & 8'($urandom);
            EI_N  = ($urandom_range(0, 7) == 0);
            inta  = ($urandom_range(0, 3) == 0);
            eoi   = ($urandom_range(0, 3) == 0);
            rst_N = ($urandom_range(0, 99) != 0);
            tick();
            for (int m = 0; m < 2; m++) begin
                got  = (m == 1) ? {int_e, vec_e, pend_e, isr_e} : {int_l, vec_l, pend_l, isr_l};
                want = {m_int[m], m_vec[m], m_pend[m], m_isr[m]};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL rand[%0d] mode%0d: got int=%b vec=%0d pend=%h isr=%h want int=%b vec=%0d pend=%h isr=%h",
                             n, m, got[19], got[18:16], got[15:8], got[7:0], want[19], want[18:16], want[15:8], want[7:0]);
                end
            end
        end
        rst_N = 1'b1; inta = 1'b0; eoi = 1'b0; EI_N = 1'b0; mask = 8'h00; irq_N = 8'hFF;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_preempt();
        test_cancel();
        test_level();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
